// File: rtl/adc_conv_sequencer_pkg.sv
// Shared types and timing defaults for the ADC conversion sequencer.
package adc_conv_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PWRUP    = 3'd1,
      ST_READY    = 3'd2,
      ST_CONV     = 3'd3,
      ST_WAIT_EOC = 3'd4,
      ST_RD_SETUP = 3'd5,
      ST_READ     = 3'd6,
      ST_RECOVER  = 3'd7
   } state_t;

   localparam int unsigned DEF_DW          = 8;
   localparam int unsigned DEF_PWRUP_CYC   = 1000;
   localparam int unsigned DEF_CONV_LOW    = 4;
   localparam int unsigned DEF_EOC_TO      = 255;
   localparam int unsigned DEF_RD_DELAY    = 2;
   localparam int unsigned DEF_RD_LOW      = 6;
   localparam int unsigned DEF_SAMPLE_AT   = 2;
   localparam int unsigned DEF_RECOVER_CYC = 3;

   // Phase counter width: enough bits to hold the longer of the two long phases.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// Sample output stream: registered data with valid/ready handshake.
interface adc_conv_sequencer_if #(parameter int unsigned DW = 8);
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/adc_conv_sequencer_rate_timer.sv
// Auto-conversion rate timer: counts 0..rate_div and pulses on wrap.
module adc_conv_sequencer_rate_timer (
   input  logic        clk_100M,
   input  logic        Reset,
   input  logic        en,
   input  logic        clear,
   input  logic [15:0] rate_div,
   output logic        tick
);

   logic [15:0] count;

   // Free-running count while enabled; clear forces a fresh period.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (en) begin
         if (count == rate_div) begin
            count <= '0;
            tick  <= 1'b1;
         end else begin
            count <= count + 16'd1;
            tick  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer for a parallel ADC: power-up, CONVST, EOC wait,
// RD-strobed readback, recovery, and a valid/ready sample register.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | ADC powered down, waiting for en
// PWRUP       | PD high, waiting PWRUP_CYC cycles for the ADC to settle
// READY       | waiting for a start or rate-timer trigger
// CONV        | CONVST low for CONV_LOW cycles
// WAIT_EOC    | waiting for synced EOC low, bounded by EOC_TO
// RD_SETUP    | RD_DELAY cycles before the read strobe
// READ        | RD low for RD_LOW cycles, data captured at SAMPLE_AT
// RECOVER     | RECOVER_CYC quiet cycles, then wait for EOC high
module adc_conv_sequencer
   import adc_conv_sequencer_pkg::*;
#(
   parameter int unsigned   DW          = DEF_DW,
   parameter int unsigned   PWRUP_CYC   = DEF_PWRUP_CYC,
   parameter int unsigned   CONV_LOW    = DEF_CONV_LOW,
   parameter int unsigned   EOC_TO      = DEF_EOC_TO,
   parameter int unsigned   RD_DELAY    = DEF_RD_DELAY,
   parameter int unsigned   RD_LOW      = DEF_RD_LOW,
   parameter int unsigned   SAMPLE_AT   = DEF_SAMPLE_AT,
   parameter int unsigned   RECOVER_CYC = DEF_RECOVER_CYC,
   parameter logic [DW-1:0] RST_VAL     = '0
)(
   input  logic                        clk_100M,
   input  logic                        Reset,
   input  logic                        en,
   input  logic                        start,
   input  logic                        auto_mode,
   input  logic [15:0]                 rate_div,
   input  logic                        clr_err,
   input  logic                        EOC_18,
   input  logic [DW-1:0]               DB_in,
   output logic                        CONVST_18,
   output logic                        RD_18,
   output logic                        PD_18,
   output logic                        busy,
   output logic                        timeout_err,
   output logic                        overrun,
   output logic                        trig_miss,
   adc_conv_sequencer_if.master        smp
);

   localparam int unsigned CW = cnt_width(PWRUP_CYC, EOC_TO);

   // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
   localparam logic [CW-1:0] L_PWRUP = CW'(PWRUP_CYC - 1);
   localparam logic [CW-1:0] L_CONV  = CW'(CONV_LOW - 1);
   localparam logic [CW-1:0] L_EOC   = CW'(EOC_TO - 1);
   localparam logic [CW-1:0] L_RDDLY = CW'((RD_DELAY == 0) ? 0 : RD_DELAY - 1);
   localparam logic [CW-1:0] L_RDLOW = CW'(RD_LOW - 1);
   localparam logic [CW-1:0] L_SMP   = CW'(RD_LOW - 1 - SAMPLE_AT);
   localparam logic [CW-1:0] L_REC   = CW'(RECOVER_CYC - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          eoc_meta, eoc_sync;
   logic          tick, trig;
   logic          capture, publish, set_to, set_ovr, set_miss;
   logic [DW-1:0] shadow, pub_data;

   adc_conv_sequencer_rate_timer u_rate_timer (
      .clk_100M (clk_100M),
      .Reset    (Reset),
      .en       (auto_mode & PD_18),
      .clear    (~auto_mode),
      .rate_div (rate_div),
      .tick     (tick)
   );

   // Two-flop synchroniser for the asynchronous active-low EOC pin.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         eoc_meta <= 1'b1;
         eoc_sync <= 1'b1;
      end else begin
         eoc_meta <= EOC_18;
         eoc_sync <= eoc_meta;
      end
   end

   // FSM state and phase counter registers.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, phase counter and per-cycle event decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      publish   = 1'b0;
      set_to    = 1'b0;
      trig      = auto_mode ? tick : start;
      case (state)
         ST_IDLE: begin
            if (en) begin
               state_nxt = ST_PWRUP;
               cnt_nxt   = L_PWRUP;
            end
         end
         ST_PWRUP: begin
            if (cnt == '0) state_nxt = ST_READY;
            else           cnt_nxt   = cnt - ONE;
         end
         ST_READY: begin
            if (trig) begin
               state_nxt = ST_CONV;
               cnt_nxt   = L_CONV;
            end
         end
         ST_CONV: begin
            if (cnt == '0) begin
               state_nxt = ST_WAIT_EOC;
               cnt_nxt   = L_EOC;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         ST_WAIT_EOC: begin
            if (!eoc_sync) begin
               if (RD_DELAY == 0) begin
                  state_nxt = ST_READ;
                  cnt_nxt   = L_RDLOW;
               end else begin
                  state_nxt = ST_RD_SETUP;
                  cnt_nxt   = L_RDDLY;
               end
            end else if (cnt == '0) begin
               set_to    = 1'b1;
               state_nxt = ST_RECOVER;
               cnt_nxt   = L_REC;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         ST_RD_SETUP: begin
            if (cnt == '0) begin
               state_nxt = ST_READ;
               cnt_nxt   = L_RDLOW;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         ST_READ: begin
            capture = (cnt == L_SMP);
            if (cnt == '0) begin
               publish   = 1'b1;
               state_nxt = ST_RECOVER;
               cnt_nxt   = L_REC;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         ST_RECOVER: begin
            if (cnt != '0)    cnt_nxt   = cnt - ONE;
            else if (eoc_sync) state_nxt = ST_READY;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Disable wins from any state and throws away the in-flight sample.
      if (!en) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
         capture   = 1'b0;
         publish   = 1'b0;
         set_to    = 1'b0;
      end
   end

   // When sampling on the last RD-low cycle, the shadow is being loaded on the same edge.
   assign pub_data = capture ? DB_in : shadow;
   assign set_ovr  = publish & smp.data_valid & ~smp.data_ready;
   assign set_miss = auto_mode & tick & (state != ST_READY);

   // ADC pin and status outputs, registered from the next state.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         CONVST_18 <= 1'b1;
         RD_18     <= 1'b1;
         PD_18     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         CONVST_18 <= (state_nxt != ST_CONV);
         RD_18     <= (state_nxt != ST_READ);
         PD_18     <= (state_nxt != ST_IDLE);
         busy      <= (state_nxt inside {ST_CONV, ST_WAIT_EOC, ST_RD_SETUP, ST_READ, ST_RECOVER});
      end
   end

   // Shadow capture and the valid/ready output register; newest sample wins.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         shadow         <= RST_VAL;
         smp.data_out   <= RST_VAL;
         smp.data_valid <= 1'b0;
      end else begin
         if (capture) shadow <= DB_in;
         if (publish) begin
            smp.data_out   <= pub_data;
            smp.data_valid <= 1'b1;
         end else if (smp.data_valid && smp.data_ready) begin
            smp.data_valid <= 1'b0;
         end
      end
   end

   // Sticky error flags; clr_err beats a same-cycle set.
   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
         trig_miss   <= 1'b0;
      end else if (clr_err) begin
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
         trig_miss   <= 1'b0;
      end else begin
         if (set_to)   timeout_err <= 1'b1;
         if (set_ovr)  overrun     <= 1'b1;
         if (set_miss) trig_miss   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a simple EOC-driving ADC model.
module tb_adc_conv_sequencer;

   logic        clk_100M = 1'b0;
   logic        Reset;
   logic        en, start, auto_mode, clr_err;
   logic [15:0] rate_div;
   logic        EOC_18 = 1'b1;
   logic [7:0]  DB_in;
   logic        CONVST_18, RD_18, PD_18, busy, timeout_err, overrun, trig_miss;

   logic model_on  = 1'b0;
   logic eoc_stuck = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   n, m, t_now, t_prev;

   adc_conv_sequencer_if #(.DW(8)) sif ();

   adc_conv_sequencer dut (
      .clk_100M    (clk_100M),
      .Reset       (Reset),
      .en          (en),
      .start       (start),
      .auto_mode   (auto_mode),
      .rate_div    (rate_div),
      .clr_err     (clr_err),
      .EOC_18      (EOC_18),
      .DB_in       (DB_in),
      .CONVST_18   (CONVST_18),
      .RD_18       (RD_18),
      .PD_18       (PD_18),
      .busy        (busy),
      .timeout_err (timeout_err),
      .overrun     (overrun),
      .trig_miss   (trig_miss),
      .smp         (sif.master)
   );

   always #5 clk_100M = ~clk_100M;

   always @(posedge clk_100M) cyc <= cyc + 1;

   // ADC model: EOC falls 20 clocks after CONVST rises, returns high after RD rises.
   always begin
      @(posedge CONVST_18);
      if (model_on && !eoc_stuck) begin
         repeat (20) @(posedge clk_100M);
         #1 EOC_18 = 1'b0;
         @(posedge RD_18);
         #1 EOC_18 = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_100M);
      start = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; en = 1'b0; start = 1'b0; auto_mode = 1'b0; clr_err = 1'b0;
      rate_div = 16'd0; DB_in = 8'h00; sif.data_ready = 1'b0;
      #3 Reset = 1'b0;
      #1;
      check("rst_convst", 32'(CONVST_18), 32'(1));
      check("rst_rd",     32'(RD_18), 32'(1));
      check("rst_pd",     32'(PD_18), 32'(0));
      check("rst_data",   32'(sif.data_out), 32'(0));
      check("rst_valid",  32'(sif.data_valid), 32'(0));
      check("rst_flags",  32'({timeout_err, overrun, trig_miss, busy}), 32'(0));
      #10 Reset = 1'b1;

      // Power-up and single-shot conversion
      @(negedge clk_100M);
      model_on = 1'b1;
      en = 1'b1;
      repeat (1010) @(negedge clk_100M);
      check("pwrup_pd", 32'(PD_18), 32'(1));
      check("pwrup_idle_busy", 32'(busy), 32'(0));
      pulse_start();
      n = 0;
      while (CONVST_18 !== 1'b0 && n < 50) begin @(negedge clk_100M); n++; end
      n = 0;
      while (CONVST_18 === 1'b0 && n < 50) begin n++; @(negedge clk_100M); end
      check("conv_low_cycles", 32'(n), 32'(4));
      m = 0;
      while (RD_18 !== 1'b0 && m < 400) begin @(negedge clk_100M); m++; end
      check("rd_fall_after_convst", 32'(m), 32'(25));
      n = 0;
      while (RD_18 === 1'b0 && n < 20) begin
         DB_in = (n == 2) ? 8'hA5 : 8'h5A;
         @(negedge clk_100M);
         n++;
      end
      check("rd_low_cycles", 32'(n), 32'(6));
      check("single_data", 32'(sif.data_out), 32'(8'hA5));
      check("single_valid", 32'(sif.data_valid), 32'(1));
      check("recover_busy", 32'(busy), 32'(1));
      repeat (10) @(negedge clk_100M);
      check("single_done_busy", 32'(busy), 32'(0));
      sif.data_ready = 1'b1;
      @(negedge clk_100M);
      sif.data_ready = 1'b0;
      check("handshake_clears", 32'(sif.data_valid), 32'(0));

      // EOC timeout
      eoc_stuck = 1'b1;
      pulse_start();
      n = 0;
      while (CONVST_18 !== 1'b1 && n < 50) begin @(negedge clk_100M); n++; end
      n = 0;
      while (timeout_err !== 1'b1 && n < 400) begin @(negedge clk_100M); n++; end
      check("timeout_cycles", 32'(n), 32'(255));
      check("timeout_no_valid", 32'(sif.data_valid), 32'(0));
      repeat (10) @(negedge clk_100M);
      check("timeout_back_ready", 32'({busy, PD_18}), 32'(2'b01));
      eoc_stuck = 1'b0;
      clr_err = 1'b1;
      @(negedge clk_100M);
      clr_err = 1'b0;
      check("clr_timeout", 32'(timeout_err), 32'(0));

      // Auto mode, period 100, consumer always ready
      rate_div = 16'd99;
      sif.data_ready = 1'b1;
      auto_mode = 1'b1;
      t_prev = 0;
      for (int j = 0; j < 3; j++) begin
         n = 0;
         while (CONVST_18 !== 1'b0 && n < 300) begin @(negedge clk_100M); n++; end
         t_now = cyc;
         check("auto_fall_seen", 32'(n < 300), 32'(1));
         if (j > 0) check("auto_period", 32'(t_now - t_prev), 32'(100));
         t_prev = t_now;
         DB_in = 8'h30 + 8'(j);
         n = 0;
         while (sif.data_valid !== 1'b1 && n < 100) begin @(negedge clk_100M); n++; end
         check("auto_data", 32'(sif.data_out), 32'(8'h30 + j));
         @(negedge clk_100M);
         check("auto_one_handshake", 32'(sif.data_valid), 32'(0));
      end
      auto_mode = 1'b0;
      repeat (20) @(negedge clk_100M);
      check("auto_no_flags", 32'({timeout_err, overrun, trig_miss}), 32'(0));

      // Auto mode faster than a conversion: missed triggers and overrun
      rate_div = 16'd9;
      sif.data_ready = 1'b0;
      DB_in = 8'h77;
      auto_mode = 1'b1;
      n = 0;
      while (sif.data_valid !== 1'b1 && n < 200) begin @(negedge clk_100M); n++; end
      check("fast_first_valid", 32'(sif.data_valid), 32'(1));
      check("fast_first_no_ovr", 32'(overrun), 32'(0));
      n = 0;
      while (RD_18 !== 1'b0 && n < 200) begin @(negedge clk_100M); n++; end
      n = 0;
      while (RD_18 !== 1'b1 && n < 20) begin @(negedge clk_100M); n++; end
      check("fast_overrun", 32'(overrun), 32'(1));
      auto_mode = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 50) begin @(negedge clk_100M); n++; end
      repeat (3) @(negedge clk_100M);
      check("fast_trig_miss", 32'(trig_miss), 32'(1));
      check("fast_data", 32'(sif.data_out), 32'(8'h77));
      clr_err = 1'b1;
      @(negedge clk_100M);
      clr_err = 1'b0;
      check("fast_clr", 32'({overrun, trig_miss}), 32'(0));
      sif.data_ready = 1'b1;
      @(negedge clk_100M);
      sif.data_ready = 1'b0;

      // Disable during READ, then full power-up before the next conversion
      DB_in = 8'hCC;
      pulse_start();
      n = 0;
      while (RD_18 !== 1'b0 && n < 200) begin @(negedge clk_100M); n++; end
      en = 1'b0;
      @(negedge clk_100M);
      check("abort_rd", 32'(RD_18), 32'(1));
      check("abort_pd", 32'(PD_18), 32'(0));
      check("abort_no_valid", 32'({sif.data_valid, busy}), 32'(0));
      check("abort_data_kept", 32'(sif.data_out), 32'(8'h77));
      repeat (3) @(negedge clk_100M);
      en = 1'b1;
      start = 1'b1;
      n = 0;
      while (CONVST_18 !== 1'b0 && n < 1200) begin @(negedge clk_100M); n++; end
      start = 1'b0;
      check("repower_wait", 32'(n), 32'(1002));
      n = 0;
      while (sif.data_valid !== 1'b1 && n < 100) begin @(negedge clk_100M); n++; end
      check("repower_data", 32'(sif.data_out), 32'(8'hCC));

      // Asynchronous reset in the middle of READ
      pulse_start();
      n = 0;
      while (RD_18 !== 1'b0 && n < 200) begin @(negedge clk_100M); n++; end
      #2 Reset = 1'b0;
      #1;
      check("async_rst_convst", 32'(CONVST_18), 32'(1));
      check("async_rst_rd", 32'(RD_18), 32'(1));
      check("async_rst_pd", 32'(PD_18), 32'(0));
      check("async_rst_data", 32'(sif.data_out), 32'(0));
      check("async_rst_valid", 32'(sif.data_valid), 32'(0));
      #20 Reset = 1'b1;
      @(negedge clk_100M);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
